// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-port round-robin arbiter in front of sdram_interface.
//
// Each port issues whole-burst commands: one write burst of BURST_LENGTH words or one read
// burst. One port is granted at a time. The arbiter drives the sdram_interface user side and
// routes the returned read beats back to the owning port.
//
// Optional feature macro: SDRAM_ARB_TIMEOUT_EN
//   defined   - RD_WAIT watchdog. If RD_TIMEOUT cycles pass with no read beat while beats
//               are still outstanding, rd_timeout pulses for one cycle and the burst is
//               abandoned.
//   undefined - no watchdog; rd_timeout is tied low and RD_WAIT waits indefinitely.
//
// Ports:
//   clk, reset                  system clock; synchronous active-low reset
//   mN_cmd_valid/ready/we/addr  port N (N=0,1) burst command handshake
//   mN_wr_data, mN_wr_next      port N write word, consumed on each edge with wr_next=1
//   mN_rd_data, mN_rd_valid     port N returned read word and strobe
//   sd_ready, sd_valid,         sdram_interface status and read data
//   sd_data_out
//   sd_address, sd_data_in,     sdram_interface user-side command signals
//   sd_read, sd_write
//   rd_timeout                  read-wait watchdog pulse

module sdram_arbiter #(
  parameter int unsigned BURST_LENGTH = 4,
  parameter int unsigned ADDR_W       = 25,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned RD_TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              reset,
  // port 0
  input  logic              m0_cmd_valid,
  output logic              m0_cmd_ready,
  input  logic              m0_cmd_we,
  input  logic [ADDR_W-1:0] m0_cmd_addr,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic              m0_wr_next,
  output logic [DATA_W-1:0] m0_rd_data,
  output logic              m0_rd_valid,
  // port 1
  input  logic              m1_cmd_valid,
  output logic              m1_cmd_ready,
  input  logic              m1_cmd_we,
  input  logic [ADDR_W-1:0] m1_cmd_addr,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic              m1_wr_next,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic              m1_rd_valid,
  // sdram_interface user side
  input  logic              sd_ready,
  input  logic              sd_valid,
  input  logic [DATA_W-1:0] sd_data_out,
  output logic [ADDR_W-1:0] sd_address,
  output logic [DATA_W-1:0] sd_data_in,
  output logic              sd_read,
  output logic              sd_write,
  output logic              rd_timeout
);

  localparam int unsigned BeatW = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BURST_LENGTH - 1);

  // Elaboration-time sanity check on the configuration.
  if (BURST_LENGTH < 2 || RD_TIMEOUT < 2) begin : g_bad_param
    $error("sdram_arbiter: BURST_LENGTH and RD_TIMEOUT must both be at least 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StWrBurst,
    StRdIssue,
    StRdWait,
    StGap
  } state_e;

  state_e              state_q, state_d;
  logic [BeatW-1:0]    beat_q, beat_d;
  logic                owner_q, owner_d;
  logic                last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                sd_write_q, sd_write_d;
  logic                sd_read_q, sd_read_d;
  logic [ADDR_W-1:0]   sd_address_q, sd_address_d;
  logic                m0_wr_next_q, m0_wr_next_d;
  logic                m1_wr_next_q, m1_wr_next_d;
  logic                rd_timeout_q, rd_timeout_d;

  logic grant0, grant1, arb_en, accept, timeout_now, beat_in, wr_active;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int unsigned TimerW = $clog2(RD_TIMEOUT + 1);
  logic [TimerW-1:0] timer_q, timer_d;
  // A pending pulse means this is the last RD_WAIT cycle of an abandoned burst.
  assign timeout_now = rd_timeout_q;
`else
  assign timeout_now = 1'b0;
`endif

  // Round robin: on a tie the port that did not win last time is granted.
  assign grant0 = m0_cmd_valid & (~m1_cmd_valid | last_grant_q);
  assign grant1 = m1_cmd_valid & (~m0_cmd_valid | ~last_grant_q);
  assign arb_en = reset & sd_ready & (state_q == StIdle);

  assign m0_cmd_ready = arb_en & grant0;
  assign m1_cmd_ready = arb_en & grant1;
  assign accept       = m0_cmd_ready | m1_cmd_ready;

  // Read beats and write data are combinational pass-throughs for the owner.
  assign beat_in     = reset & (state_q == StRdWait) & sd_valid & ~timeout_now;
  assign m0_rd_valid = beat_in & ~owner_q;
  assign m1_rd_valid = beat_in & owner_q;
  assign m0_rd_data  = m0_rd_valid ? sd_data_out : '0;
  assign m1_rd_data  = m1_rd_valid ? sd_data_out : '0;

  assign wr_active  = reset & (state_q == StWrBurst);
  assign sd_data_in = wr_active ? (owner_q ? m1_wr_data : m0_wr_data) : '0;

  assign sd_write   = sd_write_q;
  assign sd_read    = sd_read_q;
  assign sd_address = sd_address_q;
  assign m0_wr_next = m0_wr_next_q;
  assign m1_wr_next = m1_wr_next_q;
  assign rd_timeout = rd_timeout_q;

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          owner_d      = m1_cmd_ready;
          last_grant_d = m1_cmd_ready;
          addr_d       = m1_cmd_ready ? m1_cmd_addr : m0_cmd_addr;
          beat_d       = '0;
          state_d      = (m1_cmd_ready ? m1_cmd_we : m0_cmd_we) ? StWrBurst : StRdIssue;
        end
      end
      StWrBurst: begin
        if (beat_q == LastBeat) begin
          state_d = StGap;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      StRdIssue: begin
        beat_d  = '0;
        state_d = StRdWait;
      end
      StRdWait: begin
        if (timeout_now) begin
          state_d = StGap;
        end else if (sd_valid) begin
          if (beat_q == LastBeat) begin
            state_d = StGap;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Command outputs are registered and follow the state being entered.
    sd_write_d   = (state_d == StWrBurst);
    sd_read_d    = (state_d == StRdIssue);
    sd_address_d = (sd_write_d | sd_read_d) ? addr_d : '0;
    m0_wr_next_d = sd_write_d & ~owner_d;
    m1_wr_next_d = sd_write_d & owner_d;
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  // Timer restarts on RD_WAIT entry and on every beat; the pulse is raised so that it
  // coincides with the RD_TIMEOUT-th silent cycle, which is also the last RD_WAIT cycle.
  always_comb begin
    timer_d = timer_q;
    if (state_q != StRdWait || sd_valid) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end
    rd_timeout_d = (state_d == StRdWait) && (timer_d == TimerW'(RD_TIMEOUT - 1));
  end
`else
  always_comb begin
    rd_timeout_d = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      beat_q       <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      sd_write_q   <= 1'b0;
      sd_read_q    <= 1'b0;
      sd_address_q <= '0;
      m0_wr_next_q <= 1'b0;
      m1_wr_next_q <= 1'b0;
      rd_timeout_q <= 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      timer_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      sd_write_q   <= sd_write_d;
      sd_read_q    <= sd_read_d;
      sd_address_q <= sd_address_d;
      m0_wr_next_q <= m0_wr_next_d;
      m1_wr_next_q <= m1_wr_next_d;
      rd_timeout_q <= rd_timeout_d;
`ifdef SDRAM_ARB_TIMEOUT_EN
      timer_q      <= timer_d;
`endif
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Testbench for sdram_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a transaction-level model.

module tb_sdram_arbiter;

  localparam int BL = 4;
  localparam int AW = 25;
  localparam int DW = 16;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          m0_cmd_valid = 0, m1_cmd_valid = 0;
  logic          m0_cmd_ready, m1_cmd_ready;
  logic          m0_cmd_we = 0, m1_cmd_we = 0;
  logic [AW-1:0] m0_cmd_addr = '0, m1_cmd_addr = '0;
  logic [DW-1:0] m0_wr_data = '0, m1_wr_data = '0;
  logic          m0_wr_next, m1_wr_next;
  logic [DW-1:0] m0_rd_data, m1_rd_data;
  logic          m0_rd_valid, m1_rd_valid;
  logic          sd_ready = 0, sd_valid = 0;
  logic [DW-1:0] sd_data_out = '0;
  logic [AW-1:0] sd_address;
  logic [DW-1:0] sd_data_in;
  logic          sd_read, sd_write, rd_timeout;

  sdram_arbiter #(
    .BURST_LENGTH(BL),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .RD_TIMEOUT  (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .m0_cmd_valid(m0_cmd_valid),
    .m0_cmd_ready(m0_cmd_ready),
    .m0_cmd_we   (m0_cmd_we),
    .m0_cmd_addr (m0_cmd_addr),
    .m0_wr_data  (m0_wr_data),
    .m0_wr_next  (m0_wr_next),
    .m0_rd_data  (m0_rd_data),
    .m0_rd_valid (m0_rd_valid),
    .m1_cmd_valid(m1_cmd_valid),
    .m1_cmd_ready(m1_cmd_ready),
    .m1_cmd_we   (m1_cmd_we),
    .m1_cmd_addr (m1_cmd_addr),
    .m1_wr_data  (m1_wr_data),
    .m1_wr_next  (m1_wr_next),
    .m1_rd_data  (m1_rd_data),
    .m1_rd_valid (m1_rd_valid),
    .sd_ready    (sd_ready),
    .sd_valid    (sd_valid),
    .sd_data_out (sd_data_out),
    .sd_address  (sd_address),
    .sd_data_in  (sd_data_in),
    .sd_read     (sd_read),
    .sd_write    (sd_write),
    .rd_timeout  (rd_timeout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------------------
  // Transaction-level model: a burst is described by its accept cycle, owner, kind and
  // address; its visible behaviour is derived from the cycle offset and beats received.
  // ---------------------------------------------------------------------------------------
  bit            m_busy = 0;
  bit            m_last = 1;
  bit            m_own;
  bit            m_we;
  logic [AW-1:0] m_addr;
  int            m_acc, m_end, m_beats, m_ref;

  always @(negedge clk) begin
    int off;
    bit e_wr, e_rd, e_wait, e_to, e_beat, g0, g1;
    if (!reset) begin
      chk("rst_cmd_ready0", m0_cmd_ready, 0);
      chk("rst_cmd_ready1", m1_cmd_ready, 0);
      chk("rst_rd_valid", {m1_rd_valid, m0_rd_valid}, 0);
      chk("rst_rd_data", {m1_rd_data, m0_rd_data}, 0);
      m_busy = 0;
      m_last = 1;
    end else begin
      off    = cyc - m_acc;
      e_wr   = m_busy && m_we && off >= 1 && off <= BL;
      e_rd   = m_busy && !m_we && off == 1;
      e_to   = 0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      e_to   = m_busy && !m_we && off >= 2 && m_beats < BL && (cyc - m_ref == TO);
`endif
      e_wait = m_busy && !m_we && off >= 2 && m_beats < BL && !e_to;
      e_beat = e_wait && sd_valid;
      g0     = !m_busy && sd_ready && m0_cmd_valid && (!m1_cmd_valid || m_last);
      g1     = !m_busy && sd_ready && m1_cmd_valid && (!m0_cmd_valid || !m_last);

      chk("cmd_ready0", m0_cmd_ready, g0);
      chk("cmd_ready1", m1_cmd_ready, g1);
      chk("sd_write", sd_write, e_wr);
      chk("sd_read", sd_read, e_rd);
      if (e_wr || e_rd) chk("sd_address", sd_address, m_addr);
      if (e_wr) chk("sd_data_in", sd_data_in, m_own ? m1_wr_data : m0_wr_data);
      chk("wr_next0", m0_wr_next, e_wr && !m_own);
      chk("wr_next1", m1_wr_next, e_wr && m_own);
      chk("rd_valid0", m0_rd_valid, e_beat && !m_own);
      chk("rd_valid1", m1_rd_valid, e_beat && m_own);
      if (e_beat) chk("rd_data", m_own ? m1_rd_data : m0_rd_data, sd_data_out);
      chk("rd_timeout", rd_timeout, e_to);

      if (e_beat) begin
        m_beats++;
        m_ref = cyc;
        if (m_beats == BL) m_end = cyc + 1;
      end
      if (e_to) m_end = cyc + 1;
      if (m_busy && cyc == m_end) m_busy = 0;
      if (g0 || g1) begin
        m_busy  = 1;
        m_acc   = cyc;
        m_own   = g1;
        m_we    = g1 ? m1_cmd_we : m0_cmd_we;
        m_addr  = g1 ? m1_cmd_addr : m0_cmd_addr;
        m_last  = g1;
        m_beats = 0;
        m_ref   = cyc + 1;
        m_end   = m_we ? cyc + BL + 1 : 32'h7fff_ffff;
      end
    end
    cyc++;
  end

  // ---------------------------------------------------------------------------------------
  // Directed scenarios with hand-computed expectations, then random traffic.
  // ---------------------------------------------------------------------------------------
  logic [DW-1:0] wr_exp [4] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003};
  logic [DW-1:0] rd_exp [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  bit            vpat   [7] = '{1, 0, 1, 1, 0, 0, 1};
  int            gport[$];
  int            gcyc[$];

  initial begin
    int w0, w1, nwr, b, k;

    // Reset with both ports requesting writes.
    reset        = 0;
    sd_ready     = 1;
    m0_cmd_valid = 1;
    m1_cmd_valid = 1;
    m0_cmd_we    = 1;
    m1_cmd_we    = 1;
    m0_cmd_addr  = {2'b00, 13'h0123, 10'h010};
    m1_cmd_addr  = 25'h1ABCDEF;
    m0_wr_data   = 16'hA000;
    m1_wr_data   = 16'hB000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("d_rst_ready", {m1_cmd_ready, m0_cmd_ready}, 0);
      if (i > 0) chk("d_rst_cmd", {sd_write, sd_read, rd_timeout}, 0);
      if (i > 0) chk("d_rst_addr", sd_address, 0);
      tick();
    end
    reset = 1;

    // Continuous writes from both ports: grants alternate every 6 cycles.
    w0  = 0;
    w1  = 0;
    nwr = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (m0_cmd_ready) begin gport.push_back(0); gcyc.push_back(i); end
      if (m1_cmd_ready) begin gport.push_back(1); gcyc.push_back(i); end
      if (sd_write) nwr++;
      if (i >= 1 && i <= 4) begin
        chk("d_wr_write", sd_write, 1);
        chk("d_wr_data", sd_data_in, wr_exp[i-1]);
        chk("d_wr_addr", sd_address, 25'h0048C10);
        chk("d_wr_next", {m1_wr_next, m0_wr_next}, 2'b01);
      end
      if (i == 5) chk("d_wr_gap", sd_write, 0);
      if (m0_wr_next) w0++;
      if (m1_wr_next) w1++;
      tick();
      m0_wr_data = 16'hA000 + 16'(w0);
      m1_wr_data = 16'hB000 + 16'(w1);
    end
    m0_cmd_valid = 0;
    m1_cmd_valid = 0;
    chk("d_grant_count", gport.size(), 4);
    if (gport.size() == 4) begin
      chk("d_grant_order", {gport[0][0], gport[1][0], gport[2][0], gport[3][0]}, 4'b0101);
      chk("d_grant_cycles", {8'(gcyc[0]), 8'(gcyc[1]), 8'(gcyc[2]), 8'(gcyc[3])},
          32'h00_06_0C_12);
    end
    chk("d_write_cycles", nwr, 16);

    // Stray sd_valid while idle, then a port 1 read.
    sd_valid    = 1;
    sd_data_out = 16'hDEAD;
    @(negedge clk);
    chk("d_stray_idle", {m1_rd_valid, m0_rd_valid}, 0);
    tick();
    sd_valid     = 0;
    m1_cmd_valid = 1;
    m1_cmd_we    = 0;
    m1_cmd_addr  = {2'b10, 13'h0222, 10'h005};
    @(negedge clk);
    chk("d_rd_grant", {m1_cmd_ready, m0_cmd_ready}, 2'b10);
    tick();
    m1_cmd_valid = 0;
    @(negedge clk);
    chk("d_rd_issue", sd_read, 1);
    chk("d_rd_addr", sd_address, 25'h1088805);
    tick();
    b = 0;
    for (int j = 0; j < 7; j++) begin
      sd_valid    = vpat[j];
      sd_data_out = vpat[j] ? rd_exp[b] : 16'h5A5A;
      @(negedge clk);
      chk("d_rd_valid1", m1_rd_valid, vpat[j]);
      chk("d_rd_valid0", m0_rd_valid, 0);
      if (vpat[j]) begin
        chk("d_rd_data", m1_rd_data, rd_exp[b]);
        b++;
      end
      tick();
    end
    sd_valid = 1;
    @(negedge clk);
    chk("d_stray_gap", {m1_rd_valid, m0_rd_valid}, 0);
    tick();
    sd_valid = 0;

    // sd_ready low holds off the grant.
    m0_cmd_valid = 1;
    m0_cmd_we    = 1;
    sd_ready     = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("d_nrdy_ready", m0_cmd_ready, 0);
      chk("d_nrdy_cmd", {sd_write, sd_read}, 0);
      tick();
    end
    sd_ready = 1;
    @(negedge clk);
    chk("d_nrdy_grant", m0_cmd_ready, 1);
    tick();
    m0_cmd_valid = 0;
    repeat (6) tick();

    // Reset in the middle of a write burst.
    m0_cmd_valid = 1;
    @(negedge clk);
    chk("d_mid_grant", m0_cmd_ready, 1);
    tick();
    m0_cmd_valid = 0;
    @(negedge clk);
    chk("d_mid_write", sd_write, 1);
    tick();
    reset = 0;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("d_mid_abort", {sd_write, m0_wr_next}, 0);
    tick();
    reset = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("d_mid_quiet", sd_write, 0);
      tick();
    end

`ifdef SDRAM_ARB_TIMEOUT_EN
    // Read with only two beats returned: watchdog fires TO cycles after the last beat.
    m0_cmd_valid = 1;
    m0_cmd_we    = 0;
    m0_cmd_addr  = 25'h0155AA3;
    @(negedge clk);
    chk("d_to_grant", m0_cmd_ready, 1);
    tick();
    m0_cmd_valid = 0;
    m0_cmd_we    = 1;
    @(negedge clk);
    tick();
    for (int i = 0; i < 2; i++) begin
      sd_valid = 1;
      @(negedge clk);
      chk("d_to_beat", m0_rd_valid, 1);
      tick();
    end
    sd_valid = 0;
    k = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      k++;
      if (rd_timeout) break;
      tick();
    end
    chk("d_to_delay", k, TO);
    tick();
    m0_cmd_valid = 1;
    @(negedge clk);
    chk("d_to_gap", {rd_timeout, m0_cmd_ready}, 0);
    tick();
    @(negedge clk);
    chk("d_to_idle", m0_cmd_ready, 1);
    tick();
    m0_cmd_valid = 0;
    repeat (6) tick();
`endif

    // Random traffic, including occasional resets.
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 199) != 0);
      m0_cmd_valid = ($urandom_range(0, 2) != 0);
      m1_cmd_valid = ($urandom_range(0, 2) != 0);
      m0_cmd_we    = $urandom_range(0, 1) == 1;
      m1_cmd_we    = $urandom_range(0, 1) == 1;
      m0_cmd_addr  = AW'($urandom);
      m1_cmd_addr  = AW'($urandom);
      m0_wr_data   = DW'($urandom);
      m1_wr_data   = DW'($urandom);
      sd_ready     = ($urandom_range(0, 7) != 0);
      sd_valid     = ($urandom_range(0, 2) == 0);
      sd_data_out  = DW'($urandom);
      @(negedge clk);
      tick();
    end
    reset = 1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

endmodule
